// File: rtl/mmu_tile_controller_if.sv
// Command/status bundle between mmu_tile_controller and its neighbours
// (Rx decoder, input buffers, MMU array, activation/pooling/FIFO path).
//   master : controller view (drives buffer/MMU/FIFO controls, reads commands and dims)
//   slave  : environment view (drives commands, dims, FIFO status; reads controls)
// op_cycles exists only when MMU_PERF_CNT_EN is defined.
interface mmu_tile_controller_if #(
  parameter int unsigned ACC_SIZE = 24,
  parameter int unsigned DIM_W    = 8,
  parameter int unsigned TIDX_W   = 5
) ();

  logic                       load;
  logic                       buffer_a_b;
  logic                       multiply;
  logic signed [ACC_SIZE-1:0] bias_in;
  logic [1:0]                 activation_in;
  logic [1:0]                 pooling_in;
  logic [DIM_W-1:0]           dim_x_a;
  logic [DIM_W-1:0]           dim_y_a;
  logic [DIM_W-1:0]           dim_x_b;
  logic [DIM_W-1:0]           dim_y_b;
  logic                       fifo_almst_full;

  logic                       mpu_ready;
  logic [1:0]                 buf_a_cmd;
  logic [1:0]                 buf_b_cmd;
  logic [TIDX_W-1:0]          buf_a_row_t;
  logic [TIDX_W-1:0]          buf_a_col_t;
  logic [TIDX_W-1:0]          buf_b_row_t;
  logic [TIDX_W-1:0]          buf_b_col_t;
  logic                       mmu_clear;
  logic                       mmu_shift;
  logic                       out_valid;
  logic                       out_last;
  logic [DIM_W-1:0]           tile_rows;
  logic [DIM_W-1:0]           tile_cols;
  logic signed [ACC_SIZE-1:0] bias_ctrl;
  logic [1:0]                 activation_ctrl;
  logic [1:0]                 pooling_ctrl;
  logic                       fifo_dim_wr;
  logic [DIM_W-1:0]           dim_x_fifo;
  logic [DIM_W-1:0]           dim_y_fifo;
  logic                       dim_error;
`ifdef MMU_PERF_CNT_EN
  logic [31:0]                op_cycles;
`endif

  modport master (
    input  load, buffer_a_b, multiply, bias_in, activation_in, pooling_in,
           dim_x_a, dim_y_a, dim_x_b, dim_y_b, fifo_almst_full,
    output mpu_ready, buf_a_cmd, buf_b_cmd,
           buf_a_row_t, buf_a_col_t, buf_b_row_t, buf_b_col_t,
           mmu_clear, mmu_shift, out_valid, out_last, tile_rows, tile_cols,
           bias_ctrl, activation_ctrl, pooling_ctrl,
           fifo_dim_wr, dim_x_fifo, dim_y_fifo, dim_error
`ifdef MMU_PERF_CNT_EN
           , op_cycles
`endif
  );

  modport slave (
    output load, buffer_a_b, multiply, bias_in, activation_in, pooling_in,
           dim_x_a, dim_y_a, dim_x_b, dim_y_b, fifo_almst_full,
    input  mpu_ready, buf_a_cmd, buf_b_cmd,
           buf_a_row_t, buf_a_col_t, buf_b_row_t, buf_b_col_t,
           mmu_clear, mmu_shift, out_valid, out_last, tile_rows, tile_cols,
           bias_ctrl, activation_ctrl, pooling_ctrl,
           fifo_dim_wr, dim_x_fifo, dim_y_fifo, dim_error
`ifdef MMU_PERF_CNT_EN
           , op_cycles
`endif
  );

endinterface

// File: rtl/mmu_tile_controller.sv
// Tiled MMU controller: splits A(dim_x_a x dim_y_a) * B(dim_x_b x dim_y_b) into
// MMU_SIZE x MMU_SIZE output tiles (row-major, column tile inner) and
// accumulates each over the K tiles. Sequences buffer SEND, MMU clear/shift
// and output-FIFO dimension writes.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : mmu_tile_controller_if.master (commands, dims, FIFO status in;
//            buffer commands/tile indices, MMU controls, latched modes,
//            FIFO dims, dim_error out). All outputs are registered.
// Optional feature: define MMU_PERF_CNT_EN to add bus.op_cycles, a saturating
// count of cycles from an accepted multiply until mpu_ready returns.
module mmu_tile_controller #(
  parameter int unsigned ACC_SIZE = 24,
  parameter int unsigned MMU_SIZE = 10,
  parameter int unsigned DIM_W    = 8,
  parameter int unsigned TIDX_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mmu_tile_controller_if.master bus
);

  localparam int unsigned CNT_W = $clog2(2 * MMU_SIZE);

  localparam logic [DIM_W-1:0] M_DIM      = DIM_W'(MMU_SIZE);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(MMU_SIZE - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(2 * MMU_SIZE - 1);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_SEND  = 2'b10,
    CMD_CLEAR = 2'b11
  } buf_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_FIFO,
    S_FEED,
    S_FLUSH,
    S_DRAIN
  } state_e;

  // Ceil(d/2): output dimension after 2x2 pooling.
  function automatic logic [DIM_W-1:0] ceil_half(input logic [DIM_W-1:0] d);
    return (d >> 1) + {{(DIM_W-1){1'b0}}, d[0]};
  endfunction

  // Valid extent of a tile given the remaining rows/cols from its origin.
  function automatic logic [DIM_W-1:0] tile_extent(input logic [DIM_W-1:0] rem);
    return (rem > M_DIM) ? M_DIM : rem;
  endfunction

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [TIDX_W-1:0]          rt_q, rt_d, ct_q, ct_d, kt_q, kt_d;
  // Remaining extents from the current tile origin replace any division.
  logic [DIM_W-1:0]           row_rem_q, row_rem_d, col_rem_q, col_rem_d, k_rem_q, k_rem_d;
  logic [DIM_W-1:0]           dxa_q, dxa_d, dya_q, dya_d, dxb_q, dxb_d, dyb_q, dyb_d;

  logic                       mpu_ready_q, mpu_ready_d;
  logic [1:0]                 buf_a_cmd_q, buf_a_cmd_d, buf_b_cmd_q, buf_b_cmd_d;
  logic [TIDX_W-1:0]          buf_a_row_t_q, buf_a_row_t_d, buf_a_col_t_q, buf_a_col_t_d;
  logic [TIDX_W-1:0]          buf_b_row_t_q, buf_b_row_t_d, buf_b_col_t_q, buf_b_col_t_d;
  logic                       mmu_clear_q, mmu_clear_d, mmu_shift_q, mmu_shift_d;
  logic                       out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DIM_W-1:0]           tile_rows_q, tile_rows_d, tile_cols_q, tile_cols_d;
  logic signed [ACC_SIZE-1:0] bias_ctrl_q, bias_ctrl_d;
  logic [1:0]                 activation_ctrl_q, activation_ctrl_d;
  logic [1:0]                 pooling_ctrl_q, pooling_ctrl_d;
  logic                       fifo_dim_wr_q, fifo_dim_wr_d;
  logic [DIM_W-1:0]           dim_x_fifo_q, dim_x_fifo_d, dim_y_fifo_q, dim_y_fifo_d;
  logic                       dim_error_q, dim_error_d;
`ifdef MMU_PERF_CNT_EN
  logic [31:0]                op_cycles_q, op_cycles_d;
`endif

  logic                       accept;
  logic                       last_tile;
  logic                       send;
  logic [TIDX_W-1:0]          send_kt;
  logic [DIM_W-1:0]           row;

  // Next-state and next-output logic.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    rt_d              = rt_q;
    ct_d              = ct_q;
    kt_d              = kt_q;
    row_rem_d         = row_rem_q;
    col_rem_d         = col_rem_q;
    k_rem_d           = k_rem_q;
    dxa_d             = dxa_q;
    dya_d             = dya_q;
    dxb_d             = dxb_q;
    dyb_d             = dyb_q;
    mpu_ready_d       = mpu_ready_q;
    buf_a_cmd_d       = CMD_NONE;
    buf_b_cmd_d       = CMD_NONE;
    buf_a_row_t_d     = buf_a_row_t_q;
    buf_a_col_t_d     = buf_a_col_t_q;
    buf_b_row_t_d     = buf_b_row_t_q;
    buf_b_col_t_d     = buf_b_col_t_q;
    mmu_clear_d       = 1'b0;
    mmu_shift_d       = 1'b0;
    out_valid_d       = 1'b0;
    out_last_d        = 1'b0;
    tile_rows_d       = tile_rows_q;
    tile_cols_d       = tile_cols_q;
    bias_ctrl_d       = bias_ctrl_q;
    activation_ctrl_d = activation_ctrl_q;
    pooling_ctrl_d    = pooling_ctrl_q;
    fifo_dim_wr_d     = 1'b0;
    dim_x_fifo_d      = dim_x_fifo_q;
    dim_y_fifo_d      = dim_y_fifo_q;
    dim_error_d       = 1'b0;
    accept            = 1'b0;
    send              = 1'b0;
    send_kt           = '0;
    row               = '0;
    last_tile         = (row_rem_q <= M_DIM) && (col_rem_q <= M_DIM);

    unique case (state_q)
      S_IDLE: begin
        // load wins over a simultaneous multiply.
        if (bus.load) begin
          if (bus.buffer_a_b) buf_b_cmd_d = CMD_LOAD;
          else                buf_a_cmd_d = CMD_LOAD;
        end else if (bus.multiply) begin
          accept            = 1'b1;
          dxa_d             = bus.dim_x_a;
          dya_d             = bus.dim_y_a;
          dxb_d             = bus.dim_x_b;
          dyb_d             = bus.dim_y_b;
          bias_ctrl_d       = bus.bias_in;
          activation_ctrl_d = bus.activation_in;
          pooling_ctrl_d    = bus.pooling_in;
          mpu_ready_d       = 1'b0;
          state_d           = S_CHECK;
        end
      end

      S_CHECK: begin
        if ((dya_q != dxb_q) || (dxa_q == '0) || (dya_q == '0) ||
            (dxb_q == '0) || (dyb_q == '0)) begin
          dim_error_d = 1'b1;
          mpu_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          fifo_dim_wr_d = 1'b1;
          dim_x_fifo_d  = (pooling_ctrl_q != 2'b00) ? ceil_half(dxa_q) : dxa_q;
          dim_y_fifo_d  = (pooling_ctrl_q != 2'b00) ? ceil_half(dyb_q) : dyb_q;
          rt_d          = '0;
          ct_d          = '0;
          row_rem_d     = dxa_q;
          col_rem_d     = dyb_q;
          state_d       = S_WAIT_FIFO;
        end
      end

      S_WAIT_FIFO: begin
        // First K step of a new output tile.
        if (!bus.fifo_almst_full) begin
          send        = 1'b1;
          send_kt     = '0;
          mmu_clear_d = 1'b1;
          tile_rows_d = tile_extent(row_rem_q);
          tile_cols_d = tile_extent(col_rem_q);
          kt_d        = '0;
          k_rem_d     = dya_q;
          cnt_d       = '0;
          state_d     = S_FEED;
        end
      end

      S_FEED: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (k_rem_q <= M_DIM) begin
            state_d = S_FLUSH;
          end else begin
            send    = 1'b1;
            send_kt = kt_q + TIDX_W'(1);
            kt_d    = kt_q + TIDX_W'(1);
            k_rem_d = k_rem_q - M_DIM;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d       = '0;
          mmu_shift_d = 1'b1;
          row         = '0;
          state_d     = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DRAIN: begin
        if (cnt_q != STEP_LAST) begin
          cnt_d       = cnt_q + CNT_W'(1);
          mmu_shift_d = 1'b1;
          row         = DIM_W'(cnt_q) + DIM_W'(1);
        end else begin
          cnt_d = '0;
          if (last_tile) begin
            buf_a_cmd_d = CMD_CLEAR;
            buf_b_cmd_d = CMD_CLEAR;
            mpu_ready_d = 1'b1;
            rt_d        = '0;
            ct_d        = '0;
            kt_d        = '0;
            state_d     = S_IDLE;
          end else begin
            if (col_rem_q > M_DIM) begin
              ct_d      = ct_q + TIDX_W'(1);
              col_rem_d = col_rem_q - M_DIM;
            end else begin
              ct_d      = '0;
              col_rem_d = dyb_q;
              rt_d      = rt_q + TIDX_W'(1);
              row_rem_d = row_rem_q - M_DIM;
            end
            state_d = S_WAIT_FIFO;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A tile (rt,kt) and B tile (kt,ct) are always sent together.
    if (send) begin
      buf_a_cmd_d   = CMD_SEND;
      buf_b_cmd_d   = CMD_SEND;
      buf_a_row_t_d = rt_q;
      buf_a_col_t_d = send_kt;
      buf_b_row_t_d = send_kt;
      buf_b_col_t_d = ct_q;
    end

    // Row qualification for the row leaving the array on the next cycle.
    if (mmu_shift_d) begin
      out_valid_d = (row < tile_rows_q);
      out_last_d  = last_tile && (row == (tile_rows_q - DIM_W'(1)));
    end
  end

`ifdef MMU_PERF_CNT_EN
  // The accept cycle counts as the first cycle of the operation.
  always_comb begin
    op_cycles_d = op_cycles_q;
    if (accept)
      op_cycles_d = 32'd1;
    else if ((state_q != S_IDLE) && (op_cycles_q != 32'hFFFF_FFFF))
      op_cycles_d = op_cycles_q + 32'd1;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      rt_q              <= '0;
      ct_q              <= '0;
      kt_q              <= '0;
      row_rem_q         <= '0;
      col_rem_q         <= '0;
      k_rem_q           <= '0;
      dxa_q             <= '0;
      dya_q             <= '0;
      dxb_q             <= '0;
      dyb_q             <= '0;
      mpu_ready_q       <= 1'b1;
      buf_a_cmd_q       <= CMD_NONE;
      buf_b_cmd_q       <= CMD_NONE;
      buf_a_row_t_q     <= '0;
      buf_a_col_t_q     <= '0;
      buf_b_row_t_q     <= '0;
      buf_b_col_t_q     <= '0;
      mmu_clear_q       <= 1'b0;
      mmu_shift_q       <= 1'b0;
      out_valid_q       <= 1'b0;
      out_last_q        <= 1'b0;
      tile_rows_q       <= '0;
      tile_cols_q       <= '0;
      bias_ctrl_q       <= '0;
      activation_ctrl_q <= '0;
      pooling_ctrl_q    <= '0;
      fifo_dim_wr_q     <= 1'b0;
      dim_x_fifo_q      <= '0;
      dim_y_fifo_q      <= '0;
      dim_error_q       <= 1'b0;
`ifdef MMU_PERF_CNT_EN
      op_cycles_q       <= '0;
`endif
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      rt_q              <= rt_d;
      ct_q              <= ct_d;
      kt_q              <= kt_d;
      row_rem_q         <= row_rem_d;
      col_rem_q         <= col_rem_d;
      k_rem_q           <= k_rem_d;
      dxa_q             <= dxa_d;
      dya_q             <= dya_d;
      dxb_q             <= dxb_d;
      dyb_q             <= dyb_d;
      mpu_ready_q       <= mpu_ready_d;
      buf_a_cmd_q       <= buf_a_cmd_d;
      buf_b_cmd_q       <= buf_b_cmd_d;
      buf_a_row_t_q     <= buf_a_row_t_d;
      buf_a_col_t_q     <= buf_a_col_t_d;
      buf_b_row_t_q     <= buf_b_row_t_d;
      buf_b_col_t_q     <= buf_b_col_t_d;
      mmu_clear_q       <= mmu_clear_d;
      mmu_shift_q       <= mmu_shift_d;
      out_valid_q       <= out_valid_d;
      out_last_q        <= out_last_d;
      tile_rows_q       <= tile_rows_d;
      tile_cols_q       <= tile_cols_d;
      bias_ctrl_q       <= bias_ctrl_d;
      activation_ctrl_q <= activation_ctrl_d;
      pooling_ctrl_q    <= pooling_ctrl_d;
      fifo_dim_wr_q     <= fifo_dim_wr_d;
      dim_x_fifo_q      <= dim_x_fifo_d;
      dim_y_fifo_q      <= dim_y_fifo_d;
      dim_error_q       <= dim_error_d;
`ifdef MMU_PERF_CNT_EN
      op_cycles_q       <= op_cycles_d;
`endif
    end
  end

  assign bus.mpu_ready       = mpu_ready_q;
  assign bus.buf_a_cmd       = buf_a_cmd_q;
  assign bus.buf_b_cmd       = buf_b_cmd_q;
  assign bus.buf_a_row_t     = buf_a_row_t_q;
  assign bus.buf_a_col_t     = buf_a_col_t_q;
  assign bus.buf_b_row_t     = buf_b_row_t_q;
  assign bus.buf_b_col_t     = buf_b_col_t_q;
  assign bus.mmu_clear       = mmu_clear_q;
  assign bus.mmu_shift       = mmu_shift_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_last        = out_last_q;
  assign bus.tile_rows       = tile_rows_q;
  assign bus.tile_cols       = tile_cols_q;
  assign bus.bias_ctrl       = bias_ctrl_q;
  assign bus.activation_ctrl = activation_ctrl_q;
  assign bus.pooling_ctrl    = pooling_ctrl_q;
  assign bus.fifo_dim_wr     = fifo_dim_wr_q;
  assign bus.dim_x_fifo      = dim_x_fifo_q;
  assign bus.dim_y_fifo      = dim_y_fifo_q;
  assign bus.dim_error       = dim_error_q;
`ifdef MMU_PERF_CNT_EN
  assign bus.op_cycles       = op_cycles_q;
`endif

endmodule

// File: tb/tb_mmu_tile_controller.sv
// Directed bench for mmu_tile_controller with MMU_SIZE=4. Cycle numbers are
// relative to the cycle T in which multiply is held (rel 1 = T+1).
module tb_mmu_tile_controller;

  localparam int unsigned ACC = 24;
  localparam int unsigned M   = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned TW  = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mmu_tile_controller_if #(.ACC_SIZE(ACC), .DIM_W(DW), .TIDX_W(TW)) bus ();

  mmu_tile_controller #(
    .ACC_SIZE(ACC), .MMU_SIZE(M), .DIM_W(DW), .TIDX_W(TW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Per-operation observations.
  int ready_rel, rdy_at1, n_pair, n_send_any, n_clr, n_valid, n_last;
  int last_rel, last_valid_rel, first_send, first_shift, last_shift;
  int n_bclr, n_fwr, fdx, fdy, n_derr, derr_rel, pool_bad;
  int tr[8];
  int tc[8];

  task automatic set_dims(input int xa, input int ya, input int xb, input int yb);
    bus.dim_x_a = DW'(xa);
    bus.dim_y_a = DW'(ya);
    bus.dim_x_b = DW'(xb);
    bus.dim_y_b = DW'(yb);
  endtask

  // Pulse multiply for one cycle, then watch until mpu_ready returns.
  // fifo_almst_full is held high for cycles rel in [stall_from, stall_from+stall_len).
  task automatic run_mult(input int stall_from, input int stall_len, input int pool_exp);
    ready_rel = -1; rdy_at1 = -1; n_pair = 0; n_send_any = 0; n_clr = 0;
    n_valid = 0; n_last = 0; last_rel = -1; last_valid_rel = -1;
    first_send = -1; first_shift = -1; last_shift = -1; n_bclr = 0;
    n_fwr = 0; fdx = -1; fdy = -1; n_derr = 0; derr_rel = -1; pool_bad = 0;
    for (int i = 0; i < 8; i++) begin tr[i] = -1; tc[i] = -1; end
    @(negedge clk) bus.multiply = 1'b1;
    @(negedge clk) bus.multiply = 1'b0;
    for (int rel = 1; rel <= 400; rel++) begin
      if (rel > 1) @(negedge clk);
      bus.fifo_almst_full = (rel >= stall_from) && (rel < stall_from + stall_len);
      if (rel == 1) rdy_at1 = int'(bus.mpu_ready);
      if (bus.buf_a_cmd == 2'b10 && bus.buf_b_cmd == 2'b10) n_pair++;
      if (bus.buf_a_cmd == 2'b10 || bus.buf_b_cmd == 2'b10) begin
        n_send_any++;
        if (first_send < 0) first_send = rel;
      end
      if (bus.mmu_clear) begin
        if (n_clr < 8) begin tr[n_clr] = int'(bus.tile_rows); tc[n_clr] = int'(bus.tile_cols); end
        n_clr++;
      end
      if (bus.mmu_shift) begin
        if (first_shift < 0) first_shift = rel;
        last_shift = rel;
      end
      if (bus.out_valid) begin n_valid++; last_valid_rel = rel; end
      if (bus.out_last) begin n_last++; last_rel = rel; end
      if (bus.buf_a_cmd == 2'b11 && bus.buf_b_cmd == 2'b11) n_bclr++;
      if (bus.fifo_dim_wr) begin n_fwr++; fdx = int'(bus.dim_x_fifo); fdy = int'(bus.dim_y_fifo); end
      if (bus.dim_error) begin n_derr++; derr_rel = rel; end
      if (int'(bus.pooling_ctrl) != pool_exp) pool_bad++;
      if (rel >= 2 && bus.mpu_ready) begin
        ready_rel = rel;
        break;
      end
    end
    bus.fifo_almst_full = 1'b0;
    check_eq("op_done", longint'(ready_rel >= 0), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.load = 1'b0; bus.buffer_a_b = 1'b0; bus.multiply = 1'b0;
    bus.bias_in = '0; bus.activation_in = 2'd0; bus.pooling_in = 2'd0;
    bus.fifo_almst_full = 1'b0;
    set_dims(0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_mpu_ready", bus.mpu_ready, 1);
    check_eq("rst_buf_a_cmd", bus.buf_a_cmd, 0);
    check_eq("rst_mmu_shift", bus.mmu_shift, 0);
    check_eq("rst_tile_rows", bus.tile_rows, 0);
    check_eq("rst_fifo_dim_wr", bus.fifo_dim_wr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load + multiply together: load to B served, multiply dropped (dims 0 would error)
    bus.load = 1'b1; bus.buffer_a_b = 1'b1; bus.multiply = 1'b1;
    @(negedge clk);
    bus.load = 1'b0; bus.multiply = 1'b0;
    check_eq("load_b_cmd", bus.buf_b_cmd, 1);
    check_eq("load_a_cmd", bus.buf_a_cmd, 0);
    check_eq("load_ready", bus.mpu_ready, 1);
    @(negedge clk);
    check_eq("load_b_pulse", bus.buf_b_cmd, 0);
    check_eq("load_no_error", bus.dim_error, 0);
    bus.load = 1'b1; bus.buffer_a_b = 1'b0;
    @(negedge clk);
    bus.load = 1'b0;
    check_eq("load_a_cmd2", bus.buf_a_cmd, 1);

    // Case 1: 4x4 * 4x4
    set_dims(4, 4, 4, 4);
    bus.bias_in = -24'sd1234; bus.activation_in = 2'd2; bus.pooling_in = 2'd0;
    run_mult(0, 0, 0);
    check_eq("c1_ready_t1", rdy_at1, 0);
    check_eq("c1_ready_rel", ready_rel, 19);
    check_eq("c1_pairs", n_pair, 1);
    check_eq("c1_first_send", first_send, 3);
    check_eq("c1_clears", n_clr, 1);
    check_eq("c1_fifo_wr", n_fwr, 1);
    check_eq("c1_fifo_dx", fdx, 4);
    check_eq("c1_fifo_dy", fdy, 4);
    check_eq("c1_first_shift", first_shift, 15);
    check_eq("c1_last_shift", last_shift, 18);
    check_eq("c1_valid", n_valid, 4);
    check_eq("c1_last_cnt", n_last, 1);
    check_eq("c1_last_rel", last_rel, 18);
    check_eq("c1_bufclr", n_bclr, 1);
    check_eq("c1_bias", longint'(bus.bias_ctrl), -1234);
    check_eq("c1_act", bus.activation_ctrl, 2);
`ifdef MMU_PERF_CNT_EN
    check_eq("c7_op_cycles", bus.op_cycles, 19);
    repeat (3) @(negedge clk);
    check_eq("c7_op_cycles_hold", bus.op_cycles, 19);
`endif

    // Case 2: 6x9 * 9x5 -> 2x2 output tiles, 3 K steps each
    set_dims(6, 9, 9, 5);
    bus.activation_in = 2'd1;
    run_mult(0, 0, 0);
    check_eq("c2_pairs", n_pair, 12);
    check_eq("c2_sends", n_send_any, 12);
    check_eq("c2_clears", n_clr, 4);
    check_eq("c2_tr0", tr[0], 4);
    check_eq("c2_tr1", tr[1], 4);
    check_eq("c2_tr2", tr[2], 2);
    check_eq("c2_tr3", tr[3], 2);
    check_eq("c2_tc0", tc[0], 4);
    check_eq("c2_tc1", tc[1], 1);
    check_eq("c2_tc2", tc[2], 4);
    check_eq("c2_tc3", tc[3], 1);
    check_eq("c2_valid", n_valid, 12);
    check_eq("c2_last_cnt", n_last, 1);
    check_eq("c2_last_is_final_row", last_rel, last_valid_rel);
    check_eq("c2_bufclr", n_bclr, 1);
    check_eq("c2_ready_rel", ready_rel, 102);

    // Case 3: incompatible dims
    set_dims(2, 3, 4, 2);
    run_mult(0, 0, 0);
    check_eq("c3_err_cnt", n_derr, 1);
    check_eq("c3_err_rel", derr_rel, 2);
    check_eq("c3_ready_rel", ready_rel, 2);
    check_eq("c3_sends", n_send_any, 0);
    check_eq("c3_fifo_wr", n_fwr, 0);

    // Case 4: FIFO almost full for 10 cycles from T+2
    set_dims(4, 4, 4, 4);
    run_mult(2, 10, 0);
    check_eq("c4_first_send", first_send, 13);
    check_eq("c4_pairs", n_pair, 1);
    check_eq("c4_ready_rel", ready_rel, 29);

    // Case 5: pooling, 5x4 * 4x3
    set_dims(5, 4, 4, 3);
    bus.pooling_in = 2'd1;
    run_mult(0, 0, 1);
    check_eq("c5_fifo_dx", fdx, 3);
    check_eq("c5_fifo_dy", fdy, 2);
    check_eq("c5_pool_stable", pool_bad, 0);
    check_eq("c5_tr1", tr[1], 1);
    check_eq("c5_tc0", tc[0], 3);
    check_eq("c5_valid", n_valid, 5);
    check_eq("c5_ready_rel", ready_rel, 36);
    bus.pooling_in = 2'd0;

    // Case 6: reset pulse during FLUSH, then a normal operation
    set_dims(4, 4, 4, 4);
    @(negedge clk) bus.multiply = 1'b1;
    @(negedge clk) bus.multiply = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("c6_ready", bus.mpu_ready, 1);
    check_eq("c6_buf_a_cmd", bus.buf_a_cmd, 0);
    check_eq("c6_shift", bus.mmu_shift, 0);
    check_eq("c6_tile_cols", bus.tile_cols, 0);
    @(negedge clk);
    check_eq("c6_no_clear_a", bus.buf_a_cmd, 0);
    check_eq("c6_no_clear_b", bus.buf_b_cmd, 0);
    run_mult(0, 0, 0);
    check_eq("c6_rerun_ready", ready_rel, 19);
    check_eq("c6_rerun_valid", n_valid, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
